gba_oam_scanner: RTL and testbench
==================================

# gba_oam_scanner

Per-scanline sprite evaluator: reads the OAM attribute RAM through one read port and streams the attributes of every sprite that intersects the requested line to the object renderer. It sits between the OAM RAM (the writer side being the CPU/DMA port) and the OBJ pixel pipeline, inside the PPU. It runs once per `start` pulse, walks entries 0..127 in order and buffers hits in a small FIFO with valid/ready output.

## Interface
- `OAM_AW`, 8: OAM word address width. Entry n uses word 2n for attr0 in [15:0] and attr1 in [31:16], and word 2n+1 for attr2 in [15:0].
- `FIFO_DEPTH`, 4: hit FIFO entries, power of two, ≥2.
- `MAX_HITS`, 32: hits accepted per scan before early termination.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a scan. Ignored while `busy`.
- `line` in 8: scanline number, sampled on `start`.
- `oam_rd` out 1: read strobe.
- `oam_addr` out OAM_AW: word address.
- `oam_q` in 32: read data, valid one cycle after `oam_rd`.
- `hit_valid` out 1: FIFO head is valid.
- `hit_ready` in 1: consumer accepts the head.
- `hit_index` out 7: entry number of the head.
- `hit_attr0`, `hit_attr1`, `hit_attr2` out 16 each: attributes of the head.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when a scan ends.
- `overflow` out 1: last scan stopped at MAX_HITS. Held until the next `start`.

## Operation
- FSM states: IDLE, FETCH_A, FETCH_B, EVAL, FINISH.
- IDLE → FETCH_A on `start`. Latch `line`, set entry n=0, clear hit count, clear `overflow`.
- FETCH_A: drive `oam_rd`=1 and `oam_addr`=2n.
- FETCH_B: capture attr0/attr1 from `oam_q`. Drive `oam_rd`=1 and `oam_addr`=2n+1.
- EVAL: capture attr2 from `oam_q[15:0]` and evaluate the hit condition.
  - Hit while FIFO full: stay in EVAL with `oam_rd`=0. The captured attr2 is held in a register, not re-read.
  - Hit while FIFO not full: push `{n, attr0, attr1, attr2}` and increment the hit count.
  - If the hit count reaches MAX_HITS and n≠127: set `overflow` and go to FINISH.
  - Otherwise go to FINISH if n=127, else increment n and go to FETCH_A.
- FINISH: pulse `done` for one cycle, then go to IDLE. FIFO contents remain poppable after the scan ends.
- Hit condition:
  - Hidden when attr0[9:8]=2'b10: never a hit.
  - Shape attr0[15:14], size attr1[15:14]. Height h:
    - Square: 8/16/32/64.
    - Horizontal: 8/8/16/32.
    - Vertical: 16/32/32/64.
    - Shape 3 is prohibited and never a hit.
  - When attr0[9:8]=2'b11 (affine, double size), h is doubled.
  - Hit iff the 8-bit wrap-around difference (line − attr0[7:0]) mod 256 is < h, compared in 8 bits with h zero-extended. Y=250 with h=16 therefore hits lines 250..255 and 0..9.
- FIFO:
  - Pop when `hit_valid & hit_ready`.
  - Push requires the registered count < FIFO_DEPTH. A same-cycle pop does not unblock a push into a full FIFO.
  - A new `start` clears the FIFO.
- Reset values: all outputs 0, FIFO empty, state IDLE. Reset asserted mid-scan aborts the scan immediately. No `done` pulse is produced.

## Timing
- Entry n with no stall: FETCH_A at cycle 3n+1, FETCH_B at 3n+2, EVAL at 3n+3, counting cycle 0 as the `start` cycle.
- Full scan with no stall: `done` at cycle 385 and `busy` high on cycles 1..385.
- `busy` falls in the cycle after `done`.
- A push in EVAL makes `hit_valid` high in the next cycle, giving a latency of 3 cycles from FETCH_A.
- Each stall cycle adds exactly one cycle to the scan.
- `start` with `busy`=1 has no effect. `start` in the same cycle as FINISH is also ignored.

## Configuration
- `OAM_SCAN_CYCLE_CNT_EN` defined: adds output `scan_cycles` (11 bits).
  - Cleared on `start`, incremented every cycle while `busy`, saturating at 2047.
  - Holds its value after `done`.
  - Reset value 0.
- Undefined: the port and counter do not exist, and all other behaviour is identical.

## Structure
- Package `gba_oam_pkg`:
  - FSM state enum.
  - Attribute field bit positions (Y, mode, shape, size).
  - Hit record struct `{index, attr0, attr1, attr2}`.
  - Pure function `obj_height(shape, size, dbl)` returning 0 for prohibited.
- Sub-module `gba_oam_hit_fifo`: parameterized synchronous FIFO of hit records with count, full/empty, and a synchronous clear.

## Test plan
- Only entry 5 has Y=40 with a square 8×8 shape; `line`=44 → exactly one hit with `hit_index`=5; `done` at cycle 385; `overflow`=0.
- Entry 0 has attr0=0x0200 (hidden) with Y=line → no hit. Entry 1 uses shape 3 → no hit.
- Entry 9 has Y=250 and a vertical shape with size 0 (h=16) → hits at `line`=255 and `line`=9, no hit at `line`=10. The same entry in affine double-size mode (h=32) also hits at `line`=10.
- 10 entries hit with `hit_ready`=0 and FIFO_DEPTH=4: the FIFO fills at the 4th hit and the FSM stalls in EVAL. Release `hit_ready` → 10 records pop in index order with correct attributes.
- MAX_HITS=32 with all 128 entries hitting → scan ends after entry 31, `overflow`=1, `done` fires early, and exactly 32 records are popped.
- Assert `reset_n` low at cycle 100 of a scan → all outputs 0 the same cycle and no `done`. A new `start` afterwards runs a full scan. With `OAM_SCAN_CYCLE_CNT_EN` defined, `scan_cycles`=385 after a stall-free scan.

Source files
------------

// File: rtl/gba_oam_pkg.sv
// Shared types for the OAM scanline sprite evaluator: FSM states, attribute
// field positions, the hit record and the sprite height lookup.
package gba_oam_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH_A = 3'd1,
      ST_FETCH_B = 3'd2,
      ST_EVAL    = 3'd3,
      ST_FINISH  = 3'd4
   } state_e;

   localparam int Y_LSB     = 0;
   localparam int Y_MSB     = 7;
   localparam int MODE_LSB  = 8;
   localparam int MODE_MSB  = 9;
   localparam int SHAPE_LSB = 14;
   localparam int SHAPE_MSB = 15;
   localparam int SIZE_LSB  = 14;
   localparam int SIZE_MSB  = 15;

   localparam logic [1:0] MODE_HIDDEN     = 2'b10;
   localparam logic [1:0] MODE_AFFINE_DBL = 2'b11;
   localparam logic [6:0] LAST_ENTRY      = 7'd127;

   typedef struct packed {
      logic [6:0]  index;
      logic [15:0] attr0;
      logic [15:0] attr1;
      logic [15:0] attr2;
   } hit_rec_t;

   // Rows covered by a sprite; 0 marks the prohibited shape so it can never hit.
   function automatic logic [7:0] obj_height(input logic [1:0] shape,
                                             input logic [1:0] size,
                                             input logic       dbl);
      logic [7:0] h;
      case (shape)
         2'd0: begin
            case (size)
               2'd0:    h = 8'd8;
               2'd1:    h = 8'd16;
               2'd2:    h = 8'd32;
               default: h = 8'd64;
            endcase
         end
         2'd1: begin
            case (size)
               2'd0:    h = 8'd8;
               2'd1:    h = 8'd8;
               2'd2:    h = 8'd16;
               default: h = 8'd32;
            endcase
         end
         2'd2: begin
            case (size)
               2'd0:    h = 8'd16;
               2'd1:    h = 8'd32;
               2'd2:    h = 8'd32;
               default: h = 8'd64;
            endcase
         end
         default: h = 8'd0;
      endcase
      obj_height = dbl ? {h[6:0], 1'b0} : h;
   endfunction

endpackage

// File: rtl/gba_oam_scanner_if.sv
// OAM read port and hit record stream between the scanner (master) and the
// OAM RAM / OBJ renderer side (slave).
interface gba_oam_scanner_if #(parameter int OAM_AW = 8);
   logic              oam_rd;
   logic [OAM_AW-1:0] oam_addr;
   logic [31:0]       oam_q;
   logic              hit_valid;
   logic              hit_ready;
   logic [6:0]        hit_index;
   logic [15:0]       hit_attr0;
   logic [15:0]       hit_attr1;
   logic [15:0]       hit_attr2;

   modport master (
      output oam_rd, oam_addr, hit_valid, hit_index, hit_attr0, hit_attr1, hit_attr2,
      input  oam_q, hit_ready
   );

   modport slave (
      input  oam_rd, oam_addr, hit_valid, hit_index, hit_attr0, hit_attr1, hit_attr2,
      output oam_q, hit_ready
   );
endinterface

// File: rtl/gba_oam_hit_fifo.sv
// Synchronous FIFO of hit records with synchronous clear. The head is forced
// to zero while empty so the record outputs read 0 out of reset.
module gba_oam_hit_fifo
   import gba_oam_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clock,
   input  logic     reset_n,
   input  logic     clr,
   input  logic     push,
   input  logic     pop,
   input  hit_rec_t din,
   output hit_rec_t dout,
   output logic     full,
   output logic     empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   hit_rec_t          mem_q [DEPTH];
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              do_push_s, do_pop_s;

   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == {CW{1'b0}});
   assign do_push_s = push & ~full & ~clr;
   assign do_pop_s  = pop & ~empty & ~clr;
   assign dout      = empty ? '0 : mem_q[rd_q];

   // Pointer and occupancy update; a pop never frees room for a same-cycle push.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clr) begin
         wr_d  = {PW{1'b0}};
         rd_d  = {PW{1'b0}};
         cnt_d = {CW{1'b0}};
      end else begin
         if (do_push_s) wr_d = wr_q + PW'(1);
         else           wr_d = wr_q;
         if (do_pop_s)  rd_d = rd_q + PW'(1);
         else           rd_d = rd_q;
         cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= {PW{1'b0}};
         rd_q  <= {PW{1'b0}};
         cnt_q <= {CW{1'b0}};
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push_s) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/gba_oam_scanner.sv
// Per-scanline sprite evaluator: walks OAM entries 0..127 and queues every
// sprite covering the requested line. OAM_SCAN_CYCLE_CNT_EN adds scan_cycles.
module gba_oam_scanner
   import gba_oam_pkg::*;
#(
   parameter int OAM_AW     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_HITS   = 32
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [7:0]                line,
   gba_oam_scanner_if.master         bus,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow
`ifdef OAM_SCAN_CYCLE_CNT_EN
   ,
   output logic [10:0]               scan_cycles
`endif
);
   localparam int HCW = $clog2(MAX_HITS + 1);

   state_e            state_q, state_d;
   logic [6:0]        n_q, n_d;
   logic [7:0]        line_q, line_d;
   logic [HCW-1:0]    hit_cnt_q, hit_cnt_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       attr0_q, attr0_d, attr1_q, attr1_d, attr2_q, attr2_d;
   logic              stall_q, stall_d;
   logic              busy_q, busy_d, done_q, done_d, oam_rd_q, oam_rd_d;
   logic [OAM_AW-1:0] oam_addr_q, oam_addr_d;
   logic [15:0]       attr2_s;
   logic [7:0]        h_s, diff_s;
   logic              hit_s, push_s, clr_s, pop_s, full_s, empty_s;
   hit_rec_t          rec_s, head_s;

   // attr2 arrives from OAM on the first EVAL cycle; stalled cycles reuse the copy.
   always_comb begin
      attr2_s      = stall_q ? attr2_q : bus.oam_q[15:0];
      h_s          = obj_height(attr0_q[SHAPE_MSB:SHAPE_LSB], attr1_q[SIZE_MSB:SIZE_LSB],
                                attr0_q[MODE_MSB:MODE_LSB] == MODE_AFFINE_DBL);
      diff_s       = line_q - attr0_q[Y_MSB:Y_LSB];
      hit_s        = (attr0_q[MODE_MSB:MODE_LSB] != MODE_HIDDEN) && (diff_s < h_s);
      rec_s.index  = n_q;
      rec_s.attr0  = attr0_q;
      rec_s.attr1  = attr1_q;
      rec_s.attr2  = attr2_s;
   end

   // Scan sequencing; outputs are registered from the next state.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      line_d     = line_q;
      hit_cnt_d  = hit_cnt_q;
      overflow_d = overflow_q;
      attr0_d    = attr0_q;
      attr1_d    = attr1_q;
      attr2_d    = attr2_q;
      stall_d    = 1'b0;
      push_s     = 1'b0;
      clr_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_FETCH_A;
               line_d     = line;
               n_d        = 7'd0;
               hit_cnt_d  = {HCW{1'b0}};
               overflow_d = 1'b0;
               clr_s      = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH_A: state_d = ST_FETCH_B;
         ST_FETCH_B: begin
            attr0_d = bus.oam_q[15:0];
            attr1_d = bus.oam_q[31:16];
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            attr2_d = attr2_s;
            if (hit_s && full_s) begin
               stall_d = 1'b1;
               state_d = ST_EVAL;
            end else begin
               if (hit_s) begin
                  push_s    = 1'b1;
                  hit_cnt_d = hit_cnt_q + HCW'(1);
               end else begin
                  push_s    = 1'b0;
               end
               if ((hit_cnt_d == HCW'(MAX_HITS)) && (n_q != LAST_ENTRY)) begin
                  overflow_d = 1'b1;
                  state_d    = ST_FINISH;
               end else if (n_q == LAST_ENTRY) begin
                  state_d = ST_FINISH;
               end else begin
                  n_d     = n_q + 7'd1;
                  state_d = ST_FETCH_A;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_FINISH);
      oam_rd_d = (state_d == ST_FETCH_A) || (state_d == ST_FETCH_B);
      if (state_d == ST_FETCH_A)      oam_addr_d = OAM_AW'({n_d, 1'b0});
      else if (state_d == ST_FETCH_B) oam_addr_d = OAM_AW'({n_d, 1'b1});
      else                            oam_addr_d = {OAM_AW{1'b0}};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         n_q        <= 7'd0;
         line_q     <= 8'd0;
         hit_cnt_q  <= {HCW{1'b0}};
         overflow_q <= 1'b0;
         attr0_q    <= 16'd0;
         attr1_q    <= 16'd0;
         attr2_q    <= 16'd0;
         stall_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         oam_rd_q   <= 1'b0;
         oam_addr_q <= {OAM_AW{1'b0}};
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         line_q     <= line_d;
         hit_cnt_q  <= hit_cnt_d;
         overflow_q <= overflow_d;
         attr0_q    <= attr0_d;
         attr1_q    <= attr1_d;
         attr2_q    <= attr2_d;
         stall_q    <= stall_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         oam_rd_q   <= oam_rd_d;
         oam_addr_q <= oam_addr_d;
      end
   end

   assign pop_s = ~empty_s & bus.hit_ready;

   gba_oam_hit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (clr_s),
      .push    (push_s),
      .pop     (pop_s),
      .din     (rec_s),
      .dout    (head_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   assign bus.oam_rd    = oam_rd_q;
   assign bus.oam_addr  = oam_addr_q;
   assign bus.hit_valid = ~empty_s;
   assign bus.hit_index = head_s.index;
   assign bus.hit_attr0 = head_s.attr0;
   assign bus.hit_attr1 = head_s.attr1;
   assign bus.hit_attr2 = head_s.attr2;
   assign busy          = busy_q;
   assign done          = done_q;
   assign overflow      = overflow_q;

`ifdef OAM_SCAN_CYCLE_CNT_EN
   logic [10:0] scan_cycles_q, scan_cycles_d;

   // Saturating count of busy cycles, restarted by an accepted start.
   always_comb begin
      scan_cycles_d = scan_cycles_q;
      if ((state_q == ST_IDLE) && start)              scan_cycles_d = 11'd0;
      else if (busy_q && (scan_cycles_q != 11'h7FF))  scan_cycles_d = scan_cycles_q + 11'd1;
      else                                            scan_cycles_d = scan_cycles_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) scan_cycles_q <= 11'd0;
      else          scan_cycles_q <= scan_cycles_d;
   end

   assign scan_cycles = scan_cycles_q;
`endif
endmodule

// File: tb/tb_gba_oam_scanner.sv
// Randomized scoreboard bench for gba_oam_scanner: a sprite-rule reference
// model queues expected hit records; a negedge monitor pops and compares.
module tb_gba_oam_scanner;
   localparam int MAX_HITS = 32;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start;
   logic [7:0] line;
   logic       busy, done, overflow;
`ifdef OAM_SCAN_CYCLE_CNT_EN
   logic [10:0] scan_cycles;
`endif

   gba_oam_scanner_if #(.OAM_AW(8)) bus ();

   gba_oam_scanner #(.OAM_AW(8), .FIFO_DEPTH(4), .MAX_HITS(MAX_HITS)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .line     (line),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
`ifdef OAM_SCAN_CYCLE_CNT_EN
      ,
      .scan_cycles (scan_cycles)
`endif
   );

   always #5 clock = ~clock;

   logic [31:0] oam_mem [256];

   always @(posedge clock) begin
      if (bus.oam_rd) bus.oam_q <= oam_mem[bus.oam_addr];
   end

   int          n_vec = 0;
   int          n_err = 0;
   int          pops  = 0;
   logic [54:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Sprite height straight from the shape/size tables.
   function automatic int model_height(input int shape, input int size);
      case (shape)
         0:       return 8 << size;
         1:       return (size == 0) ? 8 : (4 << size);
         2:       return (size == 0) ? 16 : ((size == 3) ? 64 : 32);
         default: return 0;
      endcase
   endfunction

   function automatic bit model_hit(input logic [15:0] a0, input logic [15:0] a1, input logic [7:0] ln);
      int h, d;
      if (a0[9:8] == 2'b10) return 1'b0;
      h = model_height(int'(a0[15:14]), int'(a1[15:14]));
      if (a0[9:8] == 2'b11) h = 2 * h;
      d = (int'(ln) - int'(a0[7:0]) + 256) % 256;
      return d < h;
   endfunction

   // Scoreboard monitor: compare the FIFO head whenever it is accepted.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n === 1'b1 && bus.hit_valid === 1'b1 && bus.hit_ready === 1'b1) begin
            pops++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_hit: got index %0d, expected no record", bus.hit_index);
            end else begin
               check("hit_record", {9'd0, bus.hit_index, bus.hit_attr0, bus.hit_attr1, bus.hit_attr2},
                     {9'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic fill_background();
      for (int n = 0; n < 128; n++) begin
         oam_mem[2*n]   = {16'($urandom), 6'($urandom), 2'b10, 8'($urandom)};
         oam_mem[2*n+1] = $urandom;
      end
   endtask

   task automatic fill_random();
      for (int n = 0; n < 256; n++) oam_mem[n] = $urandom;
   endtask

   task automatic set_entry(input int n, input logic [15:0] a0, input logic [1:0] size);
      oam_mem[2*n] = {size, 14'($urandom), a0};
      oam_mem[2*n+1] = $urandom;
   endtask

   // ready_mode: 0 always ready, 1 random, 2 held off until cycle 200.
   task automatic run_scan(input logic [7:0] ln, input int ready_mode, input int ign_cyc,
                           input int exp_done_fixed, output int done_cyc, output int first_valid);
      int cnt, last, exp_done;
      bit ovf;
      cnt = 0; ovf = 1'b0; last = 127;
      for (int n = 0; n < 128; n++) begin
         if (model_hit(oam_mem[2*n][15:0], oam_mem[2*n][31:16], ln)) begin
            exp_q.push_back({7'(n), oam_mem[2*n][15:0], oam_mem[2*n][31:16], oam_mem[2*n+1][15:0]});
            cnt++;
            if (cnt == MAX_HITS && n != 127) begin
               ovf = 1'b1;
               last = n;
               break;
            end
         end
      end
      exp_done = (exp_done_fixed > 0) ? exp_done_fixed : 3 * (last + 1) + 1;
      pops = 0;
      done_cyc = -1;
      first_valid = -1;
      @(posedge clock); #1;
      start = 1'b1;
      line = ln;
      bus.hit_ready = (ready_mode == 0);
      @(negedge clock);
      for (int rel = 1; rel <= 3000 && done_cyc < 0; rel++) begin
         @(posedge clock); #1;
         start = (rel == ign_cyc);
         line = start ? 8'($urandom) : ln;
         case (ready_mode)
            0:       bus.hit_ready = 1'b1;
            1:       bus.hit_ready = 1'($urandom_range(0, 1));
            default: bus.hit_ready = (rel >= 200);
         endcase
         @(negedge clock);
         if (rel == 1) begin
            check("busy_at_cycle1", busy, 1);
            check("overflow_cleared", overflow, 0);
         end
         if (ready_mode == 2 && rel == 150) begin
            check("stall_busy", busy, 1);
            check("stall_no_read", bus.oam_rd, 0);
            check("stall_valid", bus.hit_valid, 1);
         end
         if (first_valid < 0 && bus.hit_valid) first_valid = rel;
         if (done) done_cyc = rel;
      end
      @(posedge clock); #1;
      start = 1'b0;
      bus.hit_ready = 1'b1;
      @(negedge clock);
      if (done_cyc < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done, expected done at %0d", exp_done);
      end else if (ready_mode != 1) begin
         check("done_cycle", done_cyc, exp_done);
      end
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      check("overflow_flag", overflow, ovf);
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clock);
      @(negedge clock);
      check("records_left", exp_q.size(), 0);
      check("pop_count", pops, cnt);
      check("fifo_drained", bus.hit_valid, 0);
      check("overflow_held", overflow, ovf);
      exp_q.delete();
   endtask

   initial begin
      int  dc, fv;
      bit  seen_done;
      reset_n = 1'b0;
      start = 1'b0;
      line = 8'd0;
      bus.hit_ready = 1'b0;
      @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_oam_rd", bus.oam_rd, 0);
      check("rst_oam_addr", bus.oam_addr, 0);
      check("rst_hit_valid", bus.hit_valid, 0);
      check("rst_hit_rec", {bus.hit_index, bus.hit_attr0, bus.hit_attr1, bus.hit_attr2}, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // Single square 8x8 hit; hidden and prohibited entries at Y=line; start during FINISH.
      fill_background();
      set_entry(5, 16'h0028, 2'd0);
      set_entry(0, 16'h022C, 2'd0);
      set_entry(1, 16'hC02C, 2'd0);
      run_scan(8'd44, 0, 385, 385, dc, fv);
      check("single_hit_pops", pops, 1);
      check("first_valid_cycle", fv, 19);
`ifdef OAM_SCAN_CYCLE_CNT_EN
      check("scan_cycles", scan_cycles, 385);
`endif

      // Y wrap-around with a vertical 8x16 sprite, then affine double size.
      fill_background();
      set_entry(9, 16'h80FA, 2'd0);
      run_scan(8'd255, 0, 0, 0, dc, fv);
      check("wrap_255_pops", pops, 1);
      run_scan(8'd9, 0, 0, 0, dc, fv);
      check("wrap_9_pops", pops, 1);
      run_scan(8'd10, 0, 0, 0, dc, fv);
      check("wrap_10_pops", pops, 0);
      set_entry(9, 16'h83FA, 2'd0);
      run_scan(8'd10, 0, 0, 0, dc, fv);
      check("dbl_10_pops", pops, 1);

      // Ten hits with the consumer stalled: entry 4 waits in EVAL from cycle 15
      // until the first pop at the end of cycle 200, adding 186 cycles.
      fill_background();
      for (int n = 0; n < 10; n++) set_entry(n, 16'h003C, 2'd0);
      run_scan(8'd60, 2, 0, 385 + 186, dc, fv);
      check("stall_pops", pops, 10);

      // Every entry hits: early stop after entry 31 with overflow.
      for (int n = 0; n < 128; n++) set_entry(n, 16'h0064, 2'd0);
      run_scan(8'd100, 0, 0, 0, dc, fv);
      check("ovf_pops", pops, MAX_HITS);
      check("ovf_set", overflow, 1);

      // Random OAM, random line, random back-pressure, ignored mid-scan start.
      for (int i = 0; i < 6; i++) begin
         fill_random();
         run_scan(8'($urandom), 1, 50, 0, dc, fv);
      end

      // Reset at cycle 100 of a scan aborts it without a done pulse.
      fill_background();
      @(posedge clock); #1;
      start = 1'b1;
      line = 8'd44;
      for (int rel = 1; rel < 100; rel++) begin
         @(posedge clock); #1;
         start = 1'b0;
         bus.hit_ready = 1'b1;
      end
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_overflow", overflow, 0);
      check("abort_oam_rd", bus.oam_rd, 0);
      check("abort_oam_addr", bus.oam_addr, 0);
      check("abort_hit_valid", bus.hit_valid, 0);
`ifdef OAM_SCAN_CYCLE_CNT_EN
      check("abort_scan_cycles", scan_cycles, 0);
`endif
      exp_q.delete();
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         if (done) seen_done = 1'b1;
      end
      check("no_done_after_reset", seen_done, 0);
      set_entry(5, 16'h0028, 2'd0);
      run_scan(8'd44, 0, 0, 385, dc, fv);
      check("post_reset_pops", pops, 1);
`ifdef OAM_SCAN_CYCLE_CNT_EN
      check("post_reset_scan_cycles", scan_cycles, 385);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
